// File: rtl/codec_cfg_seq.sv
// Purpose: walks a fixed codec register table and hands each word to the I2C word generator.
// Latency: load pulses one cycle after ready is sampled high; words are spaced by GAP_CYCLES idle cycles.
// Backpressure: waits on the ready handshake and aborts with err after TIMEOUT_CYCLES in a wait state.
//
// Ports:
//   clk, reset_n      - clock and asynchronous active-low reset
//   start, mode[1:0]  - request a sequence: 0 INIT, 1 LOOPBACK, 2 SILENCE, 3 NOP
//   ready             - word generator idle flag
//   load, data[15:0]  - one-cycle handoff of {reg_addr[6:0], value[8:0]}
//   busy, done, err   - sequence status; done/err are one-cycle pulses
module codec_cfg_seq #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        ready,
  output logic        load,
  output logic [15:0] data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    WAIT_ACC,
    GAP,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          load_q, load_d;
  logic [15:0]   data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Codec word table, {reg_addr[6:0], value[8:0]}.
  function automatic logic [15:0] table_word(input logic [1:0] m, input logic [1:0] i);
    logic [6:0] a;
    logic [8:0] v;
    a = '0;
    v = '0;
    case ({m, i})
      4'b00_00: begin a = 7'h0F; v = 9'h000; end
      4'b00_01: begin a = 7'h06; v = 9'h09F; end
      4'b00_10: begin a = 7'h09; v = 9'h000; end
      4'b01_00: begin a = 7'h06; v = 9'h00E; end
      4'b01_01: begin a = 7'h04; v = 9'h00A; end
      4'b01_10: begin a = 7'h09; v = 9'h001; end
      4'b10_00: begin a = 7'h04; v = 9'h002; end
      4'b10_01: begin a = 7'h06; v = 9'h09F; end
      default:  begin a = '0;    v = '0;     end
    endcase
    return {a, v};
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] m);
    case (m)
      2'd0:    return 2'd2;
      2'd1:    return 2'd2;
      2'd2:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    load_d  = 1'b0;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // The cycle after DONE or an abort is spent here with busy still
        // high, so start is only honoured once busy has dropped.
        busy_d = 1'b0;
        if (start && !busy_q) begin
          mode_d  = mode;
          idx_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = (mode == 2'd3) ? DONE : WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (ready) begin
          data_d  = table_word(mode_q, idx_q);
          load_d  = 1'b1;
          state_d = WAIT_ACC;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_ACC: begin
        // ready falling means the generator has taken the word.
        if (!ready) begin
          gap_d   = GAP_LAST;
          state_d = GAP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (idx_q == last_idx(mode_q)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = WAIT_RDY;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout counter restarts on every state change and only runs in the wait states.
    if ((state_d != state_q) || !((state_q == WAIT_RDY) || (state_q == WAIT_ACC))) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      idx_q   <= 2'd0;
      gap_q   <= '0;
      tmo_q   <= '0;
      load_q  <= 1'b0;
      data_q  <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      load_q  <= load_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign load = load_q;
  assign data = data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Purpose: directed self-checking bench for codec_cfg_seq with small gap/timeout overrides.
// Latency: checks exact word spacing and timeout distance against hand-computed cycle counts.
// Backpressure: a ready model drops ready two cycles after each load, or holds it stuck low/high.
module tb_codec_cfg_seq;

  localparam int GAP = 4;
  localparam int TMO = 40;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic        start   = 1'b0;
  logic [1:0]  mode    = 2'd0;
  logic        ready   = 1'b1;
  logic        load;
  logic [15:0] data;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  codec_cfg_seq #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mode    (mode),
    .ready   (ready),
    .load    (load),
    .data    (data),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Ready model: 0 = stuck low, 1 = drop for 3 cycles starting 2 cycles after each load, 2 = stuck high.
  int rdy_mode = 1;
  int since    = 100;
  always @(negedge clk) begin
    if (rdy_mode == 0) begin
      ready = 1'b0;
    end else if (rdy_mode == 2) begin
      ready = 1'b1;
    end else begin
      if (load) since = 0;
      else if (since < 100) since = since + 1;
      ready = !(since >= 2 && since <= 4);
    end
  end

  // Output monitor, sampled just after each rising edge.
  logic [15:0] ld_dat[$];
  int          ld_cyc[$];
  int          cyc        = 0;
  int          done_tot   = 0;
  int          err_tot    = 0;
  int          consec_tot = 0;
  logic        load_prev  = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (load) begin
      ld_dat.push_back(data);
      ld_cyc.push_back(cyc);
      if (load_prev) consec_tot = consec_tot + 1;
    end
    load_prev = load;
    if (done) done_tot = done_tot + 1;
    if (err)  err_tot  = err_tot + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0, input int bound, output bit expired);
    expired = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_tot != d0 || err_tot != e0) begin
        expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    #11;
    n_checks++; if (load !== 1'b0)     begin n_fail++; $display("FAIL reset_load: got %b want 0", load); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", data); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset_busy: got %b want 0", busy); end
    n_checks++; if (ld_dat.size() != 0) begin n_fail++; $display("FAIL idle_after_reset_load: got %0d loads want 0", ld_dat.size()); end
  endtask

  task automatic test_loopback;
    logic [15:0] exp_w[3];
    logic [15:0] got;
    int          l0, d0, e0;
    bit          expired;
    exp_w[0] = 16'h0C0E; exp_w[1] = 16'h080A; exp_w[2] = 16'h1201;
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    l0 = ld_dat.size(); d0 = done_tot; e0 = err_tot;
    pulse_start(2'd1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lb_first_busy: got %b want 1", busy); end
    wait_end(d0, e0, 300, expired);
    n_checks++; if (expired) begin n_fail++; $display("FAIL lb_wait: got no done within 300 cycles, want done"); end
    n_checks++; if (ld_dat.size() - l0 != 3) begin n_fail++; $display("FAIL lb_count: got %0d loads want 3", ld_dat.size() - l0); end
    for (int i = 0; i < 3; i++) begin
      got = (l0 + i < ld_dat.size()) ? ld_dat[l0 + i] : 16'hxxxx;
      n_checks++; if (got !== exp_w[i]) begin n_fail++; $display("FAIL lb_word%0d: got %h want %h", i, got, exp_w[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      int sp;
      sp = (l0 + i + 1 < ld_cyc.size()) ? ld_cyc[l0 + i + 1] - ld_cyc[l0 + i] : -1;
      n_checks++; if (sp != GAP + 4) begin n_fail++; $display("FAIL lb_spacing%0d: got %0d cycles want %0d", i, sp, GAP + 4); end
    end
    n_checks++; if (done_tot - d0 != 1) begin n_fail++; $display("FAIL lb_done: got %0d pulses want 1", done_tot - d0); end
    n_checks++; if (err_tot != e0) begin n_fail++; $display("FAIL lb_err: got %0d pulses want 0", err_tot - e0); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lb_busy_end: got %b want 0", busy); end
    n_checks++; if (data !== 16'h1201) begin n_fail++; $display("FAIL lb_data_hold: got %h want 1201", data); end
  endtask

  task automatic test_nop;
    int l0, d0, nbusy, done_at;
    l0 = ld_dat.size(); d0 = done_tot; nbusy = 0; done_at = -1;
    @(negedge clk);
    start = 1'b1;
    mode  = 2'd3;
    // start stays high through DONE and the following cycle; both must be ignored.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b0;
      if (busy) nbusy++;
      if (done && done_at < 0) done_at = i;
    end
    n_checks++; if (nbusy != 2) begin n_fail++; $display("FAIL nop_busy_cycles: got %0d want 2", nbusy); end
    n_checks++; if (done_at != 1) begin n_fail++; $display("FAIL nop_done_cycle: got %0d want 1", done_at); end
    n_checks++; if (done_tot - d0 != 1) begin n_fail++; $display("FAIL nop_done_count: got %0d want 1", done_tot - d0); end
    n_checks++; if (ld_dat.size() != l0) begin n_fail++; $display("FAIL nop_load: got %0d loads want 0", ld_dat.size() - l0); end
  endtask

  task automatic test_mode_change;
    logic [15:0] got;
    int          l0, d0, e0;
    bit          expired;
    rdy_mode = 1;
    l0 = ld_dat.size(); d0 = done_tot; e0 = err_tot;
    pulse_start(2'd2);
    repeat (3) @(negedge clk);
    start = 1'b1;
    mode  = 2'd0;
    @(negedge clk);
    start = 1'b0;
    wait_end(d0, e0, 300, expired);
    n_checks++; if (expired) begin n_fail++; $display("FAIL mc_wait: got no done within 300 cycles, want done"); end
    n_checks++; if (ld_dat.size() - l0 != 2) begin n_fail++; $display("FAIL mc_count: got %0d loads want 2", ld_dat.size() - l0); end
    got = (l0 < ld_dat.size()) ? ld_dat[l0] : 16'hxxxx;
    n_checks++; if (got !== 16'h0802) begin n_fail++; $display("FAIL mc_word0: got %h want 0802", got); end
    got = (l0 + 1 < ld_dat.size()) ? ld_dat[l0 + 1] : 16'hxxxx;
    n_checks++; if (got !== 16'h0C9F) begin n_fail++; $display("FAIL mc_word1: got %h want 0c9f", got); end
    repeat (10) @(negedge clk);
    n_checks++; if (done_tot - d0 != 1) begin n_fail++; $display("FAIL mc_done: got %0d pulses want 1", done_tot - d0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mc_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_timeout_rdy;
    int l0, d0, hit;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    l0 = ld_dat.size(); d0 = done_tot; hit = -1;
    start = 1'b1;
    mode  = 2'd0;
    for (int k = 1; k <= TMO + 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (err) begin
        hit = k;
        break;
      end
    end
    n_checks++; if (hit != TMO + 1) begin n_fail++; $display("FAIL tr_err_time: got cycle %0d want %0d", hit, TMO + 1); end
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tr_err_pulse: got %b want 0", err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tr_busy: got %b want 0", busy); end
    n_checks++; if (ld_dat.size() != l0) begin n_fail++; $display("FAIL tr_load: got %0d loads want 0", ld_dat.size() - l0); end
    n_checks++; if (done_tot != d0) begin n_fail++; $display("FAIL tr_done: got %0d pulses want 0", done_tot - d0); end
  endtask

  task automatic test_timeout_acc;
    int  l0, d0, e0;
    bit  expired;
    logic [15:0] got;
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    l0 = ld_dat.size(); d0 = done_tot; e0 = err_tot;
    pulse_start(2'd1);
    wait_end(d0, e0, 3 * TMO, expired);
    n_checks++; if (expired) begin n_fail++; $display("FAIL ta_wait: got no err within %0d cycles, want err", 3 * TMO); end
    repeat (10) @(negedge clk);
    n_checks++; if (err_tot - e0 != 1) begin n_fail++; $display("FAIL ta_err: got %0d pulses want 1", err_tot - e0); end
    n_checks++; if (ld_dat.size() - l0 != 1) begin n_fail++; $display("FAIL ta_load: got %0d loads want 1", ld_dat.size() - l0); end
    got = (l0 < ld_dat.size()) ? ld_dat[l0] : 16'hxxxx;
    n_checks++; if (got !== 16'h0C0E) begin n_fail++; $display("FAIL ta_word: got %h want 0c0e", got); end
    n_checks++; if (done_tot != d0) begin n_fail++; $display("FAIL ta_done: got %0d pulses want 0", done_tot - d0); end
    rdy_mode = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int l0, d0, e0;
    bit found;
    rdy_mode = 1;
    repeat (6) @(negedge clk);
    l0 = ld_dat.size(); d0 = done_tot; e0 = err_tot; found = 1'b0;
    pulse_start(2'd0);
    for (int i = 0; i < 300; i++) begin
      if (ld_dat.size() - l0 >= 2) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rm_second_load: got %0d loads want 2", ld_dat.size() - l0); end
    // Four cycles after the load observation the block sits in GAP after word 1.
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_pre: got %b want 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (load !== 1'b0)     begin n_fail++; $display("FAIL rm_load: got %b want 0", load); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL rm_data: got %h want 0000", data); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (done_tot != d0) begin n_fail++; $display("FAIL rm_done: got %0d pulses want 0", done_tot - d0); end
    n_checks++; if (err_tot != e0) begin n_fail++; $display("FAIL rm_err: got %0d pulses want 0", err_tot - e0); end
    n_checks++; if (ld_dat.size() - l0 != 2) begin n_fail++; $display("FAIL rm_no_more_load: got %0d loads want 2", ld_dat.size() - l0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_idle: got %b want 0", busy); end
  endtask

  task automatic test_load_spacing;
    n_checks++; if (consec_tot != 0) begin n_fail++; $display("FAIL load_consecutive: got %0d back-to-back loads want 0", consec_tot); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_nop();
    test_mode_change();
    test_timeout_rdy();
    test_timeout_acc();
    test_reset_mid();
    test_load_spacing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
